// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Fetch stage of the multi-cycle core. Owns the PC, issues one
//                instruction-memory request at a time, captures the returned
//                word into an instruction register and holds it for decode
//                until it is accepted. Applies branch/jump redirects, drops
//                the response of a request made stale by a redirect, and
//                raises a sticky error on a memory timeout or on a misaligned
//                redirect target.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk               in   1   clock, rising edge
//    rst               in   1   synchronous reset, active low (0 = reset)
//    imem_req_o        out  1   one-cycle request strobe to instruction memory
//    imem_addr_o       out  32  request address, valid while imem_req_o = 1
//    imem_rdata_i      in   32  returned instruction word
//    imem_valid_i      in   1   imem_rdata_i valid this cycle
//    instr_out_o       out  32  instruction register, feeds decode
//    pc_out_o          out  32  PC of instr_out_o
//    instr_valid_o     out  1   instr_out_o holds a fetched, unconsumed word
//    decode_ready_i    in   1   decode accepts instr_out_o this cycle
//    redirect_i        in   1   branch taken / jump: load redirect_target_i
//    redirect_target_i in   32  new PC
//    fetch_err_o       out  1   sticky error: timeout or misaligned redirect
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_valid_i,
    output logic [31:0] instr_out_o,
    output logic [31:0] pc_out_o,
    output logic        instr_valid_o,
    input  logic        decode_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        fetch_err_o
);

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [7:0]  C_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_HOLD  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] addr_q,      addr_d;
    logic        req_q,       req_d;
    logic [31:0] instr_q,     instr_d;
    logic        ivalid_q,    ivalid_d;
    logic        err_q,       err_d;
    logic [7:0]  wait_cnt_q,  wait_cnt_d;

    logic        w_redir_ok;
    logic        w_redir_bad;
    logic [7:0]  w_wait_inc;
    logic        w_timeout;
    logic [31:0] w_pc_plus4;

    // A redirect is only legal to a word-aligned target; anything else is a
    // fatal fetch error and leaves the PC where it was.
    assign w_redir_ok  = redirect_i && (redirect_target_i[1:0] == 2'b00);
    assign w_redir_bad = redirect_i && (redirect_target_i[1:0] != 2'b00);
    assign w_wait_inc  = wait_cnt_q + 8'd1;
    assign w_timeout   = (w_wait_inc == C_MAX_WAIT);
    assign w_pc_plus4  = pc_q + 32'd4;

    // ------------------------------------------------------------------------
    // Next-state and output logic. Every output is a register, so a request
    // is launched by computing req_d/addr_d on the transition into S_REQ;
    // the strobe is then high for the whole S_REQ cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = 1'b0;
        instr_d    = instr_q;
        ivalid_d   = ivalid_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_REQ: begin
                if (w_redir_bad) begin
                    state_d  = S_ERR;
                    err_d    = 1'b1;
                    ivalid_d = 1'b0;
                end else if (w_redir_ok) begin
                    // Reissue at the new target; a response to a request
                    // strobed this cycle lands while still in S_REQ and is
                    // ignored there.
                    pc_d     = redirect_target_i;
                    addr_d   = redirect_target_i;
                    req_d    = 1'b1;
                    ivalid_d = 1'b0;
                end else if (req_q) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    // First cycle after reset: the strobe is still low, so
                    // launch the request from here.
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end

            S_WAIT: begin
                if (w_redir_bad) begin
                    state_d  = S_ERR;
                    err_d    = 1'b1;
                    ivalid_d = 1'b0;
                end else if (w_redir_ok) begin
                    pc_d     = redirect_target_i;
                    ivalid_d = 1'b0;
                    if (imem_valid_i) begin
                        // The outstanding response arrives together with the
                        // redirect: nothing is left to drain, drop the word
                        // and fetch the target straight away.
                        state_d = S_REQ;
                        addr_d  = redirect_target_i;
                        req_d   = 1'b1;
                    end else begin
                        state_d    = S_DRAIN;
                        wait_cnt_d = 8'd0;
                    end
                end else if (imem_valid_i) begin
                    state_d  = S_HOLD;
                    instr_d  = imem_rdata_i;
                    ivalid_d = 1'b1;
                end else begin
                    wait_cnt_d = w_wait_inc;
                    if (w_timeout) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (w_redir_bad) begin
                    state_d  = S_ERR;
                    err_d    = 1'b1;
                    ivalid_d = 1'b0;
                end else if (w_redir_ok) begin
                    // Redirect wins over a simultaneous decode_ready: the
                    // sequential pc+4 is not taken.
                    state_d  = S_REQ;
                    pc_d     = redirect_target_i;
                    addr_d   = redirect_target_i;
                    req_d    = 1'b1;
                    ivalid_d = 1'b0;
                end else if (decode_ready_i) begin
                    state_d  = S_REQ;
                    pc_d     = w_pc_plus4;
                    addr_d   = w_pc_plus4;
                    req_d    = 1'b1;
                    ivalid_d = 1'b0;
                end
            end

            S_DRAIN: begin
                // Swallow the response of the request made stale by the
                // redirect, then fetch from the already-updated PC.
                if (imem_valid_i) begin
                    state_d = S_REQ;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                end else begin
                    wait_cnt_d = w_wait_inc;
                    if (w_timeout) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            S_ERR: begin
                ivalid_d = 1'b0;
                err_d    = 1'b1;
            end

            default: begin
                state_d  = S_ERR;
                ivalid_d = 1'b0;
                err_d    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= C_NOP;
            ivalid_q   <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            ivalid_q   <= ivalid_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_out_o   = instr_q;
    assign pc_out_o      = pc_q;
    assign instr_valid_o = ivalid_q;
    assign fetch_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch. A behavioural
//                instruction memory answers requests after a programmable
//                latency; expected request addresses and accepted
//                instructions are queued by the stimulus and compared by
//                monitors as the design produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_valid_i = 1'b0;
    logic [31:0] instr_out_o;
    logic [31:0] pc_out_o;
    logic        instr_valid_o;
    logic        decode_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_target_i = 32'h0;
    logic        fetch_err_o;

    instr_fetch #(
        .RESET_PC (C_RESET_PC),
        .MAX_WAIT (15)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_rdata_i      (imem_rdata_i),
        .imem_valid_i      (imem_valid_i),
        .instr_out_o       (instr_out_o),
        .pc_out_o          (pc_out_o),
        .instr_valid_o     (instr_valid_o),
        .decode_ready_i    (decode_ready_i),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .fetch_err_o       (fetch_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // memory model controls
    int resp_en  = 1;
    int lat      = 1;
    int rcyc     = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pend_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_instr_t;
    logic [31:0] exp_addr_q[$];
    exp_instr_t  exp_instr_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + {a[23:0], 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
    endtask

    task automatic push_instr(input logic [31:0] a);
        exp_instr_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        exp_instr_q.push_back(e);
    endtask

    task automatic check_reset_state();
        check("rst_req",    {31'h0, imem_req_o},    32'h0);
        check("rst_addr",   imem_addr_o,            C_RESET_PC);
        check("rst_pc",     pc_out_o,               C_RESET_PC);
        check("rst_instr",  instr_out_o,            C_NOP);
        check("rst_ivalid", {31'h0, instr_valid_o}, 32'h0);
        check("rst_err",    {31'h0, fetch_err_o},   32'h0);
    endtask

    // Reset for two edges, then release; cyc=0 is the release cycle.
    task automatic do_reset();
        rst = 1'b0;
        redirect_i = 1'b0;
        decode_ready_i = 1'b0;
        step();
        check_reset_state();
        step();
        rst = 1'b1;
        cyc = 0;
    endtask

    // Instruction memory: answers each strobed request 'lat' cycles later.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            rcyc = rcyc + 1;
            imem_valid_i = 1'b0;
            imem_rdata_i = 32'hDEAD_BEEF;
            if (pend_q.size() > 0 && pend_q[0].due == rcyc) begin
                imem_valid_i = 1'b1;
                imem_rdata_i = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            if (imem_req_o && resp_en != 0) begin
                pend_t p;
                p.due  = rcyc + lat;
                p.addr = imem_addr_o;
                pend_q.push_back(p);
            end
        end
    end

    // Request-address monitor
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (imem_req_o) begin
                check("addr_expected", {31'h0, exp_addr_q.size() > 0}, 32'h1);
                if (exp_addr_q.size() > 0)
                    check("imem_addr", imem_addr_o, exp_addr_q.pop_front());
            end
        end
    end

    // Accepted-instruction monitor (a redirect in the same cycle wins)
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst && instr_valid_o && decode_ready_i && !redirect_i) begin
                check("instr_expected", {31'h0, exp_instr_q.size() > 0}, 32'h1);
                if (exp_instr_q.size() > 0) begin
                    exp_instr_t e;
                    e = exp_instr_q.pop_front();
                    check("acc_instr", instr_out_o, e.instr);
                    check("acc_pc",    pc_out_o,    e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        // ---- reset, first fetch with latency 1 ----
        exp_addr_q.push_back(32'h0);
        do_reset();
        step();                                   // cycle 1
        check("c1_req", {31'h0, imem_req_o}, 32'h1);
        step();                                   // cycle 2
        check("c2_ivalid", {31'h0, instr_valid_o}, 32'h0);
        step();                                   // cycle 3
        check("c3_ivalid", {31'h0, instr_valid_o}, 32'h1);
        check("c3_instr",  instr_out_o, 32'h0050_0093);
        check("c3_pc",     pc_out_o, 32'h0);

        // ---- back-to-back with decode_ready held ----
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'hC);
        exp_addr_q.push_back(32'h10);
        push_instr(32'h0);
        push_instr(32'h4);
        push_instr(32'h8);
        push_instr(32'hC);
        decode_ready_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step(); step(); step();               // cycles 6, 9, 12
            check("seq_ivalid", {31'h0, instr_valid_o}, 32'h1);
            check("seq_pc", pc_out_o, 32'(4 * k));
        end
        step();                                   // cycle 13: REQ 0x10
        decode_ready_i = 1'b0;
        step(); step();                           // cycle 15: HOLD
        check("hold_instr", instr_out_o, mem_word(32'h10));

        // ---- redirect and decode_ready together in S_HOLD ----
        exp_addr_q.push_back(32'h40);
        redirect_i = 1'b1;
        redirect_target_i = 32'h40;
        decode_ready_i = 1'b1;
        step();                                   // cycle 16
        redirect_i = 1'b0;
        decode_ready_i = 1'b0;
        check("rh_req",    {31'h0, imem_req_o},    32'h1);
        check("rh_pc",     pc_out_o,               32'h40);
        check("rh_ivalid", {31'h0, instr_valid_o}, 32'h0);
        step(); step();                           // cycle 18
        check("rh_instr", instr_out_o, mem_word(32'h40));
        check("rh_pc2",   pc_out_o,    32'h40);

        // ---- redirect in S_WAIT, stale response one cycle later ----
        push_instr(32'h40);
        exp_addr_q.push_back(32'h44);
        exp_addr_q.push_back(32'h100);
        decode_ready_i = 1'b1;
        lat = 2;
        step();                                   // cycle 19: REQ 0x44
        decode_ready_i = 1'b0;
        step();                                   // cycle 20: WAIT
        redirect_i = 1'b1;
        redirect_target_i = 32'h100;
        step();                                   // cycle 21: DRAIN, stale word
        redirect_i = 1'b0;
        check("rw_req",    {31'h0, imem_req_o},    32'h0);
        check("rw_ivalid", {31'h0, instr_valid_o}, 32'h0);
        check("rw_pc",     pc_out_o,               32'h100);
        step();                                   // cycle 22: REQ 0x100
        check("rw_req2", {31'h0, imem_req_o}, 32'h1);
        lat = 1;
        step(); step(); step();                   // cycle 25: HOLD
        check("rw_ivalid2", {31'h0, instr_valid_o}, 32'h1);
        check("rw_instr",   instr_out_o, mem_word(32'h100));

        // ---- misaligned redirect ----
        redirect_i = 1'b1;
        redirect_target_i = 32'h102;
        step();
        redirect_i = 1'b0;
        check("mis_err",    {31'h0, fetch_err_o},   32'h1);
        check("mis_pc",     pc_out_o,               32'h100);
        check("mis_ivalid", {31'h0, instr_valid_o}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mis_req_low", {31'h0, imem_req_o},  32'h0);
            check("mis_sticky",  {31'h0, fetch_err_o}, 32'h1);
        end

        // ---- reset clears the error; memory never answers ----
        resp_en = 0;
        exp_addr_q.push_back(C_RESET_PC);
        do_reset();
        step();                                   // cycle 1
        check("to_req", {31'h0, imem_req_o}, 32'h1);
        for (int k = 2; k <= 16; k++) step();     // cycle 16: 15th WAIT cycle
        check("to_err_pre", {31'h0, fetch_err_o}, 32'h0);
        step();                                   // cycle 17
        check("to_err", {31'h0, fetch_err_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("to_req_low", {31'h0, imem_req_o}, 32'h0);
        end

        // ---- reset mid-request; stale response lands in S_REQ ----
        resp_en = 1;
        lat = 3;
        exp_addr_q.push_back(C_RESET_PC);
        exp_addr_q.push_back(C_RESET_PC);
        do_reset();
        step();                                   // request issued
        step();                                   // WAIT
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();                                   // S_REQ, stale response here
        check("mr_req", {31'h0, imem_req_o}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mr_ivalid_low", {31'h0, instr_valid_o}, 32'h0);
        end
        step();
        check("mr_ivalid", {31'h0, instr_valid_o}, 32'h1);
        check("mr_instr",  instr_out_o, mem_word(C_RESET_PC));
        step();

        check("addr_q_drained",  32'(exp_addr_q.size()),  32'h0);
        check("instr_q_drained", 32'(exp_instr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
